// File: rtl/wb_regfile_if.sv
// rtl/wb_regfile_if.sv - MEM/WB write-back inputs, decode read ports and architectural state outputs
interface wb_regfile_if #(
  parameter int CNT_W = 16
);
  logic [7:0]       wb_alu_result;
  logic [7:0]       wb_mem_data;
  logic [2:0]       wb_rd;
  logic [3:0]       wb_alu_flag;
  logic             wb_memtoreg;
  logic             wb_regwrite;
  logic [2:0]       rs1_addr;
  logic [2:0]       rs2_addr;
  logic [7:0]       rs1_data;
  logic [7:0]       rs2_data;
  logic [7:0]       wb_data;
  logic [3:0]       flags_out;
  logic [CNT_W-1:0] retire_count;

  modport slave (
    input  wb_alu_result, wb_mem_data, wb_rd, wb_alu_flag, wb_memtoreg, wb_regwrite,
    input  rs1_addr, rs2_addr,
    output rs1_data, rs2_data, wb_data, flags_out, retire_count
  );

  modport master (
    output wb_alu_result, wb_mem_data, wb_rd, wb_alu_flag, wb_memtoreg, wb_regwrite,
    output rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, wb_data, flags_out, retire_count
  );
endinterface

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back select, 8x8 register file with bypassed reads, flags and retire counter
module wb_regfile #(
  parameter int R0_ZERO = 0,
  parameter int CNT_W   = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  wb_regfile_if.slave  bus
);

  logic [7:0]       regs_q [8];
  logic [7:0]       regs_d [8];
  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       wb_sel;
  logic [7:0]       rs1_val, rs2_val;
  logic             r0_hit_wb;

  assign wb_sel    = bus.wb_memtoreg ? bus.wb_mem_data : bus.wb_alu_result;
  assign r0_hit_wb = (R0_ZERO != 0) && (bus.wb_rd == 3'd0);

  always_comb begin
    regs_d  = regs_q;
    flags_d = flags_q;
    cnt_d   = cnt_q;
    if (bus.wb_regwrite) begin
      if (!r0_hit_wb) begin
        regs_d[bus.wb_rd] = wb_sel;
      end
      if (!bus.wb_memtoreg) begin
        flags_d = bus.wb_alu_flag;
      end
      // Dropped R0 writes still retire an instruction, so they are counted.
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= 8'h00;
      end
      flags_q <= 4'h0;
      cnt_q   <= '0;
    end else begin
      regs_q  <= regs_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    rs1_val = regs_q[bus.rs1_addr];
    if (bus.wb_regwrite && (bus.rs1_addr == bus.wb_rd)) begin
      rs1_val = wb_sel;
    end
    if ((R0_ZERO != 0) && (bus.rs1_addr == 3'd0)) begin
      rs1_val = 8'h00;
    end
  end

  always_comb begin
    rs2_val = regs_q[bus.rs2_addr];
    if (bus.wb_regwrite && (bus.rs2_addr == bus.wb_rd)) begin
      rs2_val = wb_sel;
    end
    if ((R0_ZERO != 0) && (bus.rs2_addr == 3'd0)) begin
      rs2_val = 8'h00;
    end
  end

  assign bus.wb_data      = wb_sel;
  assign bus.rs1_data     = rs1_val;
  assign bus.rs2_data     = rs2_val;
  assign bus.flags_out    = flags_q;
  assign bus.retire_count = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed bench for wb_regfile with R0_ZERO=0/CNT_W=16 and R0_ZERO=1/CNT_W=4 instances
module tb_wb_regfile;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  wb_regfile_if #(.CNT_W(16)) ifa ();
  wb_regfile_if #(.CNT_W(4))  ifb ();

  wb_regfile #(.R0_ZERO(0), .CNT_W(16)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa.slave));
  wb_regfile #(.R0_ZERO(1), .CNT_W(4))  dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb.slave));

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;
  exp_t sb[$];

  logic [7:0]  ma [8];
  logic [7:0]  mb [8];
  logic [3:0]  mflags;
  logic [15:0] mcnt_a;
  logic [3:0]  mcnt_b;

  logic [7:0] t_alu, t_mem, t_flag8;
  logic [2:0] t_rd, t_a1, t_a2;
  logic [3:0] t_flag;
  logic       t_m2r, t_rw;

  function automatic logic [7:0] sel_wb();
    return t_m2r ? t_mem : t_alu;
  endfunction

  function automatic logic [7:0] mread(input logic [7:0] m [8], input bit r0z, input logic [2:0] a);
    if (r0z && a == 3'd0) return 8'h00;
    if (t_rw && a == t_rd) return sel_wb();
    return m[a];
  endfunction

  task automatic set_in(input logic [7:0] alu, input logic [7:0] mem, input logic [2:0] rd,
                        input logic [3:0] flag, input logic m2r, input logic rw,
                        input logic [2:0] a1, input logic [2:0] a2);
    t_alu = alu; t_mem = mem; t_rd = rd; t_flag = flag; t_m2r = m2r; t_rw = rw; t_a1 = a1; t_a2 = a2;
    ifa.wb_alu_result = alu; ifb.wb_alu_result = alu;
    ifa.wb_mem_data   = mem; ifb.wb_mem_data   = mem;
    ifa.wb_rd         = rd;  ifb.wb_rd         = rd;
    ifa.wb_alu_flag   = flag; ifb.wb_alu_flag  = flag;
    ifa.wb_memtoreg   = m2r; ifb.wb_memtoreg   = m2r;
    ifa.wb_regwrite   = rw;  ifb.wb_regwrite   = rw;
    ifa.rs1_addr      = a1;  ifb.rs1_addr      = a1;
    ifa.rs2_addr      = a2;  ifb.rs2_addr      = a2;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      ma[i] = 8'h00;
      mb[i] = 8'h00;
    end
    mflags = 4'h0;
    mcnt_a = 16'h0;
    mcnt_b = 4'h0;
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n && t_rw) begin
      ma[t_rd] = sel_wb();
      if (t_rd != 3'd0) mb[t_rd] = sel_wb();
      if (!t_m2r) mflags = t_flag;
      mcnt_a = mcnt_a + 16'd1;
      mcnt_b = mcnt_b + 4'd1;
    end
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_all(input string tag);
    sb.push_back('{{tag, ".a.rs1"}, {8'h00, mread(ma, 1'b0, t_a1)}});
    sb.push_back('{{tag, ".a.rs2"}, {8'h00, mread(ma, 1'b0, t_a2)}});
    sb.push_back('{{tag, ".a.wbd"}, {8'h00, sel_wb()}});
    sb.push_back('{{tag, ".a.flg"}, {12'h000, mflags}});
    sb.push_back('{{tag, ".a.cnt"}, mcnt_a});
    sb.push_back('{{tag, ".b.rs1"}, {8'h00, mread(mb, 1'b1, t_a1)}});
    sb.push_back('{{tag, ".b.rs2"}, {8'h00, mread(mb, 1'b1, t_a2)}});
    sb.push_back('{{tag, ".b.flg"}, {12'h000, mflags}});
    sb.push_back('{{tag, ".b.cnt"}, {12'h000, mcnt_b}});
  endtask

  task automatic compare_all();
    logic [15:0] obs [9];
    exp_t e;
    obs[0] = {8'h00, ifa.rs1_data};
    obs[1] = {8'h00, ifa.rs2_data};
    obs[2] = {8'h00, ifa.wb_data};
    obs[3] = {12'h000, ifa.flags_out};
    obs[4] = ifa.retire_count;
    obs[5] = {8'h00, ifb.rs1_data};
    obs[6] = {8'h00, ifb.rs2_data};
    obs[7] = {12'h000, ifb.flags_out};
    obs[8] = {12'h000, ifb.retire_count};
    for (int i = 0; i < 9; i++) begin
      if (sb.size() == 0) begin
        chk("scoreboard_underflow", 16'h0, 16'h1);
      end else begin
        e = sb.pop_front();
        chk(e.tag, obs[i], e.val);
      end
    end
  endtask

  task automatic check_all(input string tag);
    #1;
    expect_all(tag);
    compare_all();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    t_flag8 = 8'h00;
    model_reset();
    set_in(8'h00, 8'h00, 3'd0, 4'h0, 1'b0, 1'b0, 3'd1, 3'd2);
    #3;
    check_all("reset_init");

    step();
    reset_n = 1'b1;

    // ALU write with same-cycle bypass
    set_in(8'hA5, 8'h00, 3'd3, 4'b1000, 1'b0, 1'b1, 3'd3, 3'd3);
    check_all("alu_bypass");
    chk("alu_bypass_lit", {8'h00, ifa.rs1_data}, 16'h00A5);
    step();
    chk("alu_flags_lit", {12'h000, ifa.flags_out}, 16'h0008);
    chk("alu_cnt_lit", ifa.retire_count, 16'd1);
    set_in(8'h00, 8'h00, 3'd3, 4'h0, 1'b0, 1'b0, 3'd3, 3'd1);
    check_all("alu_after");
    chk("alu_after_lit", {8'h00, ifa.rs1_data}, 16'h00A5);

    // Load: data from memory, flags untouched
    set_in(8'hFF, 8'h3C, 3'd5, 4'b0111, 1'b1, 1'b1, 3'd5, 3'd3);
    check_all("load_bypass");
    step();
    set_in(8'hFF, 8'h3C, 3'd5, 4'b0111, 1'b1, 1'b0, 3'd5, 3'd3);
    check_all("load_after");
    chk("load_r5_lit", {8'h00, ifb.rs1_data}, 16'h003C);
    chk("load_flags_lit", {12'h000, ifb.flags_out}, 16'h0008);

    // Bubble: seed R2 then present an unwritten value
    set_in(8'h11, 8'h00, 3'd2, 4'b0010, 1'b0, 1'b1, 3'd1, 3'd2);
    step();
    set_in(8'h77, 8'h00, 3'd2, 4'b0101, 1'b0, 1'b0, 3'd1, 3'd2);
    check_all("bubble_same");
    chk("bubble_rs2_lit", {8'h00, ifa.rs2_data}, 16'h0011);
    step();
    check_all("bubble_after");
    chk("bubble_cnt_lit", ifa.retire_count, 16'd3);

    // R0 write: discarded only on the R0_ZERO instance, counted on both
    set_in(8'h55, 8'h00, 3'd0, 4'b0001, 1'b0, 1'b1, 3'd0, 3'd0);
    check_all("r0_same");
    chk("r0_b_same_lit", {8'h00, ifb.rs1_data}, 16'h0000);
    step();
    set_in(8'h00, 8'h00, 3'd0, 4'h0, 1'b0, 1'b0, 3'd0, 3'd2);
    check_all("r0_after");
    chk("r0_a_lit", {8'h00, ifa.rs1_data}, 16'h0055);
    chk("r0_b_lit", {8'h00, ifb.rs1_data}, 16'h0000);
    chk("r0_b_cnt_lit", {12'h000, ifb.retire_count}, 16'd4);

    // Back-to-back writes to one register
    set_in(8'h10, 8'h00, 3'd4, 4'h3, 1'b0, 1'b1, 3'd4, 3'd4);
    check_all("b2b_first");
    step();
    set_in(8'h00, 8'h20, 3'd4, 4'h6, 1'b1, 1'b1, 3'd4, 3'd4);
    check_all("b2b_second");
    step();
    set_in(8'h00, 8'h00, 3'd4, 4'h0, 1'b0, 1'b0, 3'd4, 3'd4);
    check_all("b2b_after");
    chk("b2b_last_wins_lit", {8'h00, ifa.rs1_data}, 16'h0020);

    for (int i = 0; i < 24; i++) begin
      set_in(8'($urandom), 8'($urandom), 3'($urandom), 4'($urandom), 1'($urandom),
             1'($urandom), 3'($urandom), 3'($urandom));
      check_all($sformatf("rand%0d", i));
      step();
    end

    // Asynchronous reset mid-cycle, then a write held during reset is lost
    set_in(8'h00, 8'h00, 3'd0, 4'h0, 1'b0, 1'b0, 3'd4, 3'd5);
    #2;
    reset_n = 1'b0;
    model_reset();
    check_all("reset_async");
    chk("reset_cnt_lit", ifa.retire_count, 16'd0);
    set_in(8'h99, 8'h00, 3'd6, 4'hF, 1'b0, 1'b1, 3'd1, 3'd2);
    step();
    set_in(8'h00, 8'h00, 3'd0, 4'h0, 1'b0, 1'b0, 3'd6, 3'd6);
    check_all("reset_lost");
    chk("reset_lost_lit", {8'h00, ifa.rs1_data}, 16'h0000);
    reset_n = 1'b1;

    // Counter wrap on the 4-bit instance
    for (int i = 0; i < 17; i++) begin
      set_in(8'(i), 8'h00, 3'(i), 4'(i), 1'b0, 1'b1, 3'(i), 3'd7);
      step();
    end
    set_in(8'h00, 8'h00, 3'd0, 4'h0, 1'b0, 1'b0, 3'd6, 3'd7);
    check_all("wrap");
    chk("wrap_b_lit", {12'h000, ifb.retire_count}, 16'd1);
    chk("wrap_a_lit", ifa.retire_count, 16'd17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
